// File: rtl/execute_control_unit_pkg.sv
// Shared decode constants for the execute stage: opcodes, funct fields,
// ALU operation codes and the 2-bit alu_opcode class encodings.
package execute_control_unit_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] ORI    = 6'b001101;
  localparam logic [5:0] LUI    = 6'b001111;
  localparam logic [5:0] J      = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_OR     = 2'b11
  } alu_opcode_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NONE = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/execute_control_unit_alu.sv
// Combinational ALU core; add/sub wrap modulo 2^WIDTH, unknown codes yield zero.
module arithmetic_logic_unit_core
  import execute_control_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result
);

  logic less_than;

  always_comb begin
    less_than = ($signed(operand_a) < $signed(operand_b));
    result    = '0;
    case (alu_control)
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_ADD: result = operand_a + operand_b;
      ALU_SUB: result = operand_a - operand_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, less_than};
      ALU_NOR: result = ~(operand_a | operand_b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_control_unit.sv
// Execute stage: combinational opcode/ALU-control decode feeding a registered
// ALU result and zero flag.
module execute_control_unit
  import execute_control_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             hold,
  input  logic [5:0]       opcode,
  input  logic [5:0]       function_code,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_register,
  input  logic [WIDTH-1:0] extended_immediate,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             jump,
  output logic             memory_read,
  output logic             memory_write,
  output logic             memory_to_register,
  output logic             register_destination,
  output logic             register_write,
  output logic             alu_source,
  output logic             shift_upper,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_control_signal,
  output logic [WIDTH-1:0] result_output,
  output logic             zero_output
);

  alu_opcode_e      alu_class;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_result;

  always_comb begin
    branch_eq            = 1'b0;
    branch_ne            = 1'b0;
    jump                 = 1'b0;
    memory_read          = 1'b0;
    memory_write         = 1'b0;
    memory_to_register   = 1'b0;
    register_destination = 1'b0;
    register_write       = 1'b0;
    alu_source           = 1'b0;
    shift_upper          = 1'b0;
    alu_class            = ALUOP_MEM;
    case (opcode)
      R_TYPE: begin
        register_destination = 1'b1;
        register_write       = 1'b1;
        alu_class            = ALUOP_FUNCT;
      end
      LW: begin
        alu_source         = 1'b1;
        memory_read        = 1'b1;
        memory_to_register = 1'b1;
        register_write     = 1'b1;
      end
      SW: begin
        alu_source   = 1'b1;
        memory_write = 1'b1;
      end
      BEQ: begin
        branch_eq = 1'b1;
        alu_class = ALUOP_BRANCH;
      end
      BNE: begin
        branch_ne = 1'b1;
        alu_class = ALUOP_BRANCH;
      end
      ADDI: begin
        alu_source     = 1'b1;
        register_write = 1'b1;
      end
      ORI: begin
        alu_source     = 1'b1;
        register_write = 1'b1;
        alu_class      = ALUOP_OR;
      end
      LUI: begin
        shift_upper    = 1'b1;
        alu_source     = 1'b1;
        register_write = 1'b1;
      end
      J:       jump = 1'b1;
      default: ;
    endcase
  end

  assign alu_opcode = alu_class;

  always_comb begin
    alu_control_signal = ALU_NONE;
    case (alu_class)
      ALUOP_MEM:    alu_control_signal = ALU_ADD;
      ALUOP_BRANCH: alu_control_signal = ALU_SUB;
      ALUOP_OR:     alu_control_signal = ALU_OR;
      ALUOP_FUNCT: begin
        case (function_code)
          FUNCT_ADD: alu_control_signal = ALU_ADD;
          FUNCT_SUB: alu_control_signal = ALU_SUB;
          FUNCT_AND: alu_control_signal = ALU_AND;
          FUNCT_OR:  alu_control_signal = ALU_OR;
          FUNCT_NOR: alu_control_signal = ALU_NOR;
          FUNCT_SLT: alu_control_signal = ALU_SLT;
          default:   alu_control_signal = ALU_NONE;
        endcase
      end
      default: alu_control_signal = ALU_NONE;
    endcase
  end

  assign operand_b = alu_source ? extended_immediate : operand_register;

  arithmetic_logic_unit_core #(.WIDTH(WIDTH)) alu_core (
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control_signal),
    .result      (alu_result)
  );

  // zero flag is derived from the same combinational result being captured
  always_ff @(posedge system_clock) begin
    if (reset) begin
      result_output <= '0;
      zero_output   <= 1'b1;
    end else if (!hold) begin
      result_output <= alu_result;
      zero_output   <= (alu_result == '0);
    end
  end

endmodule

// File: tb/tb_execute_control_unit.sv
// Bench for execute_control_unit: directed cases then random stimulus against
// a table-driven reference model of decode, ALU control and ALU arithmetic.
module tb_execute_control_unit;

  logic        system_clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  function_code = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_register = '0;
  logic [31:0] extended_immediate = '0;
  logic        branch_eq, branch_ne, jump, memory_read, memory_write;
  logic        memory_to_register, register_destination, register_write;
  logic        alu_source, shift_upper, zero_output;
  logic [1:0]  alu_opcode;
  logic [3:0]  alu_control_signal;
  logic [31:0] result_output;

  int total_checks = 0;
  int failed_checks = 0;

  logic [31:0] exp_result;
  logic        exp_zero;

  execute_control_unit #(.WIDTH(32)) dut (
    .system_clock         (system_clock),
    .reset                (reset),
    .hold                 (hold),
    .opcode               (opcode),
    .function_code        (function_code),
    .operand_a            (operand_a),
    .operand_register     (operand_register),
    .extended_immediate   (extended_immediate),
    .branch_eq            (branch_eq),
    .branch_ne            (branch_ne),
    .jump                 (jump),
    .memory_read          (memory_read),
    .memory_write         (memory_write),
    .memory_to_register   (memory_to_register),
    .register_destination (register_destination),
    .register_write       (register_write),
    .alu_source           (alu_source),
    .shift_upper          (shift_upper),
    .alu_opcode           (alu_opcode),
    .alu_control_signal   (alu_control_signal),
    .result_output        (result_output),
    .zero_output          (zero_output)
  );

  always #5 system_clock = ~system_clock;

  // Decode table: flags ordered {beq,bne,j,mrd,mwr,m2r,rdst,rwr,asrc,lui}
  typedef struct {
    logic [5:0] op;
    logic [9:0] flags;
    logic [1:0] aluop;
  } dec_row_t;

  typedef struct {
    logic [5:0] fn;
    logic [3:0] ctrl;
  } fn_row_t;

  dec_row_t dec_table[9];
  fn_row_t  fn_table[6];

  function automatic logic [9:0] dut_flags();
    return {branch_eq, branch_ne, jump, memory_read, memory_write,
            memory_to_register, register_destination, register_write,
            alu_source, shift_upper};
  endfunction

  function automatic logic [11:0] model_decode(input logic [5:0] op);
    for (int i = 0; i < 9; i++)
      if (dec_table[i].op == op) return {dec_table[i].flags, dec_table[i].aluop};
    return '0;
  endfunction

  function automatic logic [3:0] model_ctrl(input logic [1:0] aluop, input logic [5:0] fn);
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b01) return 4'b0110;
    if (aluop == 2'b11) return 4'b0001;
    for (int i = 0; i < 6; i++)
      if (fn_table[i].fn == fn) return fn_table[i].ctrl;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] ctrl,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ctrl == 4'b0000) return a & b;
    if (ctrl == 4'b0001) return a | b;
    if (ctrl == 4'b0010) return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    if (ctrl == 4'b0110) return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
    if (ctrl == 4'b0111) return (sa < sb) ? 32'd1 : 32'd0;
    if (ctrl == 4'b1100) return ~(a | b);
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      failed_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full cycle: drive, check decode, predict the edge, check registers.
  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] rt, input logic [31:0] imm,
                      input logic h, input logic r);
    logic [11:0] dec;
    logic [3:0]  ctrl;
    logic [31:0] b;
    opcode = op; function_code = fn; operand_a = a;
    operand_register = rt; extended_immediate = imm; hold = h; reset = r;
    #1;
    dec  = model_decode(op);
    ctrl = model_ctrl(dec[1:0], fn);
    check("decode_flags", 32'(dut_flags()), 32'(dec[11:2]));
    check("alu_opcode", 32'(alu_opcode), 32'(dec[1:0]));
    check("alu_control", 32'(alu_control_signal), 32'(ctrl));
    b = dec[3] ? imm : rt;
    if (r) begin
      exp_result = '0;
      exp_zero   = 1'b1;
    end else if (!h) begin
      exp_result = model_alu(ctrl, a, b);
      exp_zero   = (exp_result == 32'd0);
    end
    @(posedge system_clock);
    #1;
    check("result", result_output, exp_result);
    check("zero", 32'(zero_output), 32'(exp_zero));
  endtask

  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[7];
    logic [31:0] corner[6];
    dec_table[0] = '{6'b000000, 10'b0000001100, 2'b10};
    dec_table[1] = '{6'b100011, 10'b0001010110, 2'b00};
    dec_table[2] = '{6'b101011, 10'b0000100010, 2'b00};
    dec_table[3] = '{6'b000100, 10'b1000000000, 2'b01};
    dec_table[4] = '{6'b000101, 10'b0100000000, 2'b01};
    dec_table[5] = '{6'b001000, 10'b0000000110, 2'b00};
    dec_table[6] = '{6'b001101, 10'b0000000110, 2'b11};
    dec_table[7] = '{6'b001111, 10'b0000000111, 2'b00};
    dec_table[8] = '{6'b000010, 10'b0010000000, 2'b00};
    fn_table[0] = '{6'b100000, 4'b0010};
    fn_table[1] = '{6'b100010, 4'b0110};
    fn_table[2] = '{6'b100100, 4'b0000};
    fn_table[3] = '{6'b100101, 4'b0001};
    fn_table[4] = '{6'b100111, 4'b1100};
    fn_table[5] = '{6'b101010, 4'b0111};
    for (int i = 0; i < 9; i++) ops[i] = dec_table[i].op;
    ops[9] = 6'b111111;
    for (int i = 0; i < 6; i++) fns[i] = fn_table[i].fn;
    fns[6] = 6'b000000;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h8000_0000; corner[5] = 32'h1234;

    exp_result = 32'hDEAD_BEEF;
    exp_zero   = 1'b0;

    // reset state
    @(posedge system_clock); #1;
    step(6'b000000, 6'b100000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
    check("reset_result", result_output, 32'd0);
    check("reset_zero", 32'(zero_output), 32'd1);

    // R-type add
    step(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    check("add_rdst", 32'(register_destination), 32'd1);
    check("add_value", result_output, 32'd12);

    // beq equal operands
    step(6'b000100, 6'b000000, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("beq_value", result_output, 32'd0);
    check("beq_zero", 32'(zero_output), 32'd1);

    // slt signed, both operand orders
    step(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    check("slt_neg_lt_pos", result_output, 32'd1);
    step(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    check("slt_pos_lt_neg", result_output, 32'd0);

    // lw address with negative immediate
    step(6'b100011, 6'b000000, 32'h100, 32'h5555, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("lw_value", result_output, 32'hFC);

    // wrap-around add
    step(6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    check("wrap_value", result_output, 32'd0);
    check("wrap_zero", 32'(zero_output), 32'd1);

    // hold keeps value while inputs change
    step(6'b000000, 6'b100000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    step(6'b000000, 6'b100000, 32'd100, 32'd1, 32'd0, 1'b1, 1'b0);
    step(6'b001101, 6'b000000, 32'hF0, 32'd0, 32'h0F, 1'b1, 1'b0);
    check("hold_value", result_output, 32'd18);

    // reset wins over hold
    step(6'b000000, 6'b100000, 32'd100, 32'd1, 32'd0, 1'b1, 1'b1);
    check("reset_hold_value", result_output, 32'd0);
    check("reset_hold_zero", 32'(zero_output), 32'd1);

    // unknown opcode
    step(6'b111111, 6'b100010, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0);
    check("unknown_flags", 32'(dut_flags()), 32'd0);

    // randomized stream, including reset/hold interleaving
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  rop, rfn;
      logic [31:0] ra, rb, ri;
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      rfn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      ri  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 5) == 0) rb = ra;
      step(rop, rfn, ra, rb, ri, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/execute_control_unit.md
EXECUTE_CONTROL_UNIT -- requirements
Module: execute_control_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets the data-path width of operands and result.
REQ-002 system_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; clears registered outputs.
REQ-004 hold  input  1  when 1, registered outputs keep their value.
REQ-005 opcode  input  6  instruction bits [31:26].
REQ-006 function_code  input  6  instruction bits [5:0].
REQ-007 operand_a  input  WIDTH  register rs value.
REQ-008 operand_register  input  WIDTH  register rt value.
REQ-009 extended_immediate  input  WIDTH  extended immediate.
REQ-010 branch_eq, branch_ne, jump, memory_read, memory_write, memory_to_register, register_destination, register_write, alu_source, shift_upper  output  1 each  combinational decode of opcode.
REQ-011 alu_opcode  output  2  combinational decode of opcode.
REQ-012 alu_control_signal  output  4  combinational ALU operation select.
REQ-013 result_output  output  WIDTH  registered ALU result.
REQ-014 zero_output  output  1  registered; 1 when registered result is all zeros.

Function
REQ-015 Decode shall set outputs per opcode. All outputs not listed are 0.
- 000000 (R-type): register_destination=1, register_write=1, alu_opcode=10.
- 100011 (lw): alu_source=1, memory_read=1, memory_to_register=1, register_write=1, alu_opcode=00.
- 101011 (sw): alu_source=1, memory_write=1, alu_opcode=00.
- 000100 (beq): branch_eq=1, alu_opcode=01.
- 000101 (bne): branch_ne=1, alu_opcode=01.
- 001000 (addi): alu_source=1, register_write=1, alu_opcode=00.
- 001101 (ori): alu_source=1, register_write=1, alu_opcode=11.
- 001111 (lui): shift_upper=1, alu_source=1, register_write=1, alu_opcode=00.
- 000010 (j): jump=1.
REQ-016 Any other opcode shall drive every decode output to 0.
REQ-017 ALU control shall map alu_opcode to alu_control_signal as follows.
- 00 gives 0010.
- 01 gives 0110.
- 11 gives 0001.
- 10 decodes function_code: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111.
- Any other function_code under 10 gives 1111.
REQ-018 The ALU operand B shall be extended_immediate when alu_source=1, else operand_register.
REQ-019 ALU operations:
- 0000: A AND B.
- 0001: A OR B.
- 0010: A+B.
- 0110: A−B.
- 0111: signed A<B gives 1, else 0, zero-extended.
- 1100: NOR.
- Any other code: result 0.
REQ-020 Add and subtract shall wrap modulo 2^WIDTH; no overflow flag and no exception.
REQ-021 Latency: result_output and zero_output shall reflect inputs sampled at the rising edge, one cycle later.
REQ-022 Decode and alu_control_signal outputs shall have zero latency.
REQ-023 When hold=1 and reset=0, registered outputs shall keep their value.
REQ-024 zero_output shall be computed from the same ALU result that is registered, never from a stale value.

Reset
REQ-025 On a rising edge with reset=1, result_output=0 and zero_output=1, regardless of hold.
REQ-026 Reset shall not affect the combinational decode outputs.
REQ-027 Reset asserted mid-stream shall discard the in-flight result; the first result after deassertion shall come from inputs sampled at that edge.

Structure
REQ-028 A shared package shall hold:
- opcode constants (R_TYPE, LW, SW, BEQ, BNE, ADDI, ORI, LUI, J);
- funct constants;
- the 4-bit ALU operation codes;
- the 2-bit alu_opcode encodings.
REQ-029 The combinational ALU shall be one sub-module, arithmetic_logic_unit_core.
REQ-030 Opcode decode and ALU-control decode shall be in the top level.

Verification
REQ-031 R-type add test:
- stimulus: opcode=000000, funct=100000, A=5, B=7;
- response: register_destination=1, register_write=1, ctrl=0010; next cycle result=12, zero=0.
REQ-032 beq test:
- stimulus: opcode=000100, A=B=0x1234;
- response: branch_eq=1, ctrl=0110; next cycle result=0, zero=1.
REQ-033 slt test:
- stimulus: funct=101010, A=0xFFFFFFFF, B=1;
- response: result=1. Swapped operands give result=0.
REQ-034 lw test:
- stimulus: opcode=100011, A=0x100, imm=0xFFFFFFFC;
- response: alu_source=1, memory_read=1, memory_to_register=1; result=0xFC.
REQ-035 Wrap test:
- stimulus: add with A=0xFFFFFFFF, B=1;
- response: result=0, zero=1.
REQ-036 Hold and reset test:
- hold=1 with changing inputs: result unchanged;
- reset=1 together with hold=1: result=0, zero=1;
- unknown opcode 111111: all decode outputs=0.
